// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM encodings for the arbitrated UART transmitter.
//   DEFAULT_CLK_DIV : osc_clk cycles per bit (9600 Bd at 5 MHz)
//   DATA_BITS       : data bits per frame
//   IDX_W           : width of the data-bit index
//   tx_state_e      : transmitter FSM state encodings
package uart_pkg;

    localparam int unsigned DEFAULT_CLK_DIV = 521;
    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned IDX_W           = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: two-requester valid/ready byte handshake.
//   reqN_valid : requester N has a byte to send
//   reqN_data  : byte offered by requester N
//   reqN_ready : transmitter accepts the byte this cycle (when ANDed with valid)
// Modports: master = requester side, slave = transmitter side.
interface uart_tx_arb_if;
    import uart_pkg::*;

    logic                 req0_valid;
    logic                 req1_valid;
    logic [DATA_BITS-1:0] req0_data;
    logic [DATA_BITS-1:0] req1_data;
    logic                 req0_ready;
    logic                 req1_ready;

    modport master (
        output req0_valid, req1_valid, req0_data, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data,
        output req0_ready, req1_ready
    );

endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter 0..CLK_DIV-1.
//   osc_clk : clock
//   clear_i : hold counter at 0 (idle or reset)
//   tick_o  : high on the last cycle of each bit period
// Parameter CLK_DIV: cycles per bit (2..1023).
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic osc_clk,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == CNT_W'(CLK_DIV - 1));

    // Wrap to 0 after the last cycle of a period.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge osc_clk) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-requester round-robin arbiter feeding an 8N1/8N2 UART transmitter.
//   osc_clk  : clock (rising edge)
//   rst      : synchronous active-high reset
//   req      : slave modport of uart_tx_arb_if (valid/data in, ready out)
//   txd      : serial line, idle high (registered)
//   busy     : high whenever the FSM is not idle
//   grant_id : requester owning the current or most recent frame
// Parameters: CLK_DIV cycles per bit (2..1023), STOP_BITS (1 or 2).
// Macro UART_TX_ARB_PARITY_EN adds an even-parity bit between data and stop.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic           osc_clk,
    input  logic           rst,
    uart_tx_arb_if.slave   req,
    output logic           txd,
    output logic           busy,
    output logic           grant_id
);

    tx_state_e            state_q;
    logic                 txd_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic                 stop_cnt_q;
    logic                 last_grant_q;
    logic                 grant_id_q;
`ifdef UART_TX_ARB_PARITY_EN
    logic                 parity_q;
`endif

    logic                 idle;
    logic                 tick;
    logic                 accept;
    logic                 win;
    logic [DATA_BITS-1:0] win_data;

    uart_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .osc_clk (osc_clk),
        .clear_i (rst || idle),
        .tick_o  (tick)
    );

    // Arbitration: sole valid wins; on a tie the requester not granted last time wins.
    assign idle           = (state_q == ST_IDLE);
    assign req.req0_ready = idle && !rst && req.req0_valid && (!req.req1_valid || last_grant_q);
    assign req.req1_ready = idle && !rst && req.req1_valid && (!req.req0_valid || !last_grant_q);
    assign accept         = (req.req0_valid && req.req0_ready) || (req.req1_valid && req.req1_ready);
    assign win            = req.req1_ready;
    assign win_data       = win ? req.req1_data : req.req0_data;

    assign txd      = txd_q;
    assign busy     = !idle;
    assign grant_id = grant_id_q;

    // Frame FSM; txd is driven one cycle ahead so it changes with the state.
    always_ff @(posedge osc_clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            txd_q        <= 1'b1;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            stop_cnt_q   <= 1'b0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q      <= ST_START;
                        txd_q        <= 1'b0;
                        shift_q      <= win_data;
                        last_grant_q <= win;
                        grant_id_q   <= win;
`ifdef UART_TX_ARB_PARITY_EN
                        parity_q     <= ^win_data;
`endif
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state_q <= ST_DATA;
                        txd_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                            bit_idx_q <= '0;
`ifdef UART_TX_ARB_PARITY_EN
                            state_q   <= ST_PARITY;
                            txd_q     <= parity_q;
`else
                            state_q   <= ST_STOP;
                            txd_q     <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                            txd_q     <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                end
`ifdef UART_TX_ARB_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state_q <= ST_STOP;
                        txd_q   <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                            stop_cnt_q <= 1'b0;
                            state_q    <= ST_IDLE;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule
